cbc_dec_feeder: RTL and testbench
=================================

// Module: cbc_dec_feeder
// PURPOSE
//  Upstream CBC chaining and flow-control stage for the 10-round pipelined AES-128 decrypt core (decrypt_top).
//  - Accepts ciphertext blocks over valid/ready and drives the core's cipher_text input.
//  - Drives the core's vector input with the IV, or with the previous ciphertext, time-aligned to the core's XOR stage.
//  - Tracks blocks in flight and captures decrypted_plain_text into an output FIFO.
//  - The core cannot stall, so input acceptance is credit-limited to guarantee the FIFO never overflows.
// PARAMETERS
//  PIPE_LAT    12  cycles from a cipher_text register update to the matching decrypted_plain_text being valid
//  VEC_LAT     11  cycles from a cipher_text register update to the cycle the core samples vector for that block
//  FIFO_DEPTH  16  output FIFO entries (power of 2, >= 2); also the credit limit
// PORTS
//  clk                   in   1    single clock, rising edge
//  reset                 in   1    asynchronous, active-low reset
//  iv_load               in   1    load iv_in as chaining value; honoured only in IDLE
//  iv_in                 in   128  initialisation vector
//  ct_valid              in   1    ciphertext block offered
//  ct_ready              out  1    ciphertext block accepted when ct_valid & ct_ready
//  ct_data               in   128  ciphertext block
//  ct_last               in   1    marks final block of the message; sampled on accept
//  cipher_text           out  128  to core cipher_text (registered)
//  vector                out  128  to core vector (registered, delayed chain value)
//  decrypted_plain_text  in   128  from core output
//  pt_valid              out  1    plaintext available (FIFO not empty)
//  pt_ready              in   1    consumer pops when pt_valid & pt_ready
//  pt_data               out  128  plaintext at FIFO head
//  pt_last               out  1    last flag at FIFO head
//  busy                  out  1    high when state != IDLE
// BEHAVIOUR
//  Reset values (reset low)
//  - All outputs 0; state IDLE; chain, counters, shift registers and FIFO cleared.
//  - Reset mid-message discards all in-flight and buffered blocks.
//  FSM
//  - IDLE -> RUN on iv_load: chain <= iv_in.
//  - RUN -> DRAIN on an accept with ct_last=1.
//  - DRAIN -> IDLE when inflight==0 and the FIFO is empty.
//  - iv_load in RUN or DRAIN is ignored.
//  Accept (RUN only)
//  - ct_ready = (state==RUN) & (inflight + fifo_count < FIFO_DEPTH); registered-free, from current counters.
//  - On accept: cipher_text <= ct_data; chain <= ct_data; vec_pipe[0] <= old chain; vld_pipe[0] <= 1; last_pipe[0] <= ct_last.
//  - No accept: cipher_text holds; vld_pipe[0] <= 0.
//  Alignment
//  - vector = vec_pipe[VEC_LAT-1].
//  - vld_pipe and last_pipe are PIPE_LAT deep.
//  - The block entering in cycle t emerges at t+PIPE_LAT; on emerge, FIFO pushes {ct_last, decrypted_plain_text}.
//  Counters (width $clog2(FIFO_DEPTH+1))
//  - inflight: +1 on accept, -1 on emerge; simultaneous events leave it unchanged.
//  - fifo_count: +1 on push, -1 on pop; simultaneous events leave it unchanged.
//  - Credit rule guarantees no push while full; overflow is an assertion failure.
//  - Pop while empty has no effect.
//  FIFO
//  - First-word-fall-through: pt_data, pt_last and pt_valid reflect the head with no read latency.
//  - Read and write pointers wrap modulo FIFO_DEPTH.
//  Latency and ordering
//  - Throughput is one block per clock while credits remain.
//  - Accept to pt_valid is PIPE_LAT+1 cycles when the FIFO is empty.
//  - Output order equals input order.
// TESTING
//  Bench uses decrypt_top with key 2b7e151628aed2a6abf7158809cf4f3c and precomputed round keys.
//  1. NIST CBC vectors: iv_load, iv 000102030405060708090a0b0c0d0e0f.
//     - ct 7649abac8119b246cee98e9b12e9197d -> pt 6bc1bee22e409f96e93d7e117393172a.
//     - ct 5086cb9b507219ee95db113a917678b2 -> pt ae2d8a571e03ac9c9eb76fac45af8e51, pt_last=1.
//     - busy falls after the pop.
//  2. Back-to-back: 4 blocks in 4 consecutive cycles -> 4 consecutive pt_valid cycles, first at accept+PIPE_LAT+1.
//  3. Backpressure: pt_ready=0 with 40 blocks offered.
//     - ct_ready drops after exactly FIFO_DEPTH accepts; no data lost.
//     - Releasing pt_ready restores ct_ready, and all 40 plaintexts arrive in order.
//  4. Simultaneous events: accept coincides with emerge and push coincides with pop at fifo_count=FIFO_DEPTH-1 -> both counters stay constant; data correct.
//  5. Reset asserted mid-message with 5 in flight -> all outputs 0 immediately; no stale pt_valid after release; new iv_load works.
//  6. iv_load in RUN with a different IV -> ignored; chaining continues from the previous ciphertext.

Source files
------------

// File: rtl/cbc_dec_feeder.sv
// cbc_dec_feeder: CBC chaining and credit-limited flow control in front of the
// non-stallable pipelined AES-128 decrypt core. Ciphertext enters over
// valid/ready, the chaining value is delayed to meet the core's XOR stage, and
// the core's output is captured into a first-word-fall-through FIFO.
module cbc_dec_feeder #(
  parameter int DATA_W     = 128,
  parameter int PIPE_LAT   = 12,
  parameter int VEC_LAT    = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iv_load,
  input  logic [DATA_W-1:0] iv_in,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [DATA_W-1:0] ct_data,
  input  logic              ct_last,
  output logic [DATA_W-1:0] cipher_text,
  output logic [DATA_W-1:0] vector,
  input  logic [DATA_W-1:0] decrypted_plain_text,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [DATA_W-1:0] pt_data,
  output logic              pt_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   chain;
  logic [DATA_W-1:0]   vec_pipe [VEC_LAT];
  logic [PIPE_LAT-1:0] vld_pipe;
  logic [PIPE_LAT-1:0] last_pipe;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      credit_used;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
  logic                accept;
  logic                push;
  logic                pop;

  // Blocks in the core plus blocks buffered may never exceed the FIFO depth,
  // because the core cannot be stalled once a block has entered it.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign ct_ready    = (state == RUN) && (credit_used < CREDIT_MAX);
  assign accept      = ct_valid && ct_ready;
  assign push        = vld_pipe[PIPE_LAT-1];
  assign pt_valid    = (fifo_count != '0);
  assign pop         = pt_valid && pt_ready;
  assign pt_data     = fifo_mem[rd_ptr][DATA_W-1:0];
  assign pt_last     = fifo_mem[rd_ptr][DATA_W];
  assign vector      = vec_pipe[VEC_LAT-1];
  assign busy        = (state != IDLE);

  // Message FSM, chaining value and the ciphertext register feeding the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      chain       <= '0;
      cipher_text <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iv_load) begin
            chain <= iv_in;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cipher_text <= ct_data;
            chain       <= ct_data;
            if (ct_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0 && fifo_count == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay lines: chain value to the core's XOR stage, valid/last to the core output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < VEC_LAT; i++) vec_pipe[i] <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      if (accept) vec_pipe[0] <= chain;
      for (int i = 1; i < VEC_LAT; i++) vec_pipe[i] <= vec_pipe[i-1];
      vld_pipe  <= {vld_pipe[PIPE_LAT-2:0], accept};
      last_pipe <= {last_pipe[PIPE_LAT-2:0], accept && ct_last};
    end
  end

  // In-flight and buffered block counters; coincident inc/dec cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight   <= '0;
      fifo_count <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output FIFO storage; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {last_pipe[PIPE_LAT-1], decrypted_plain_text};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // A push into a full FIFO means the credit accounting has been broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(push && fifo_count == FULL_CNT));

endmodule

// File: tb/tb_cbc_dec_feeder.sv
// tb_cbc_dec_feeder: directed bench for cbc_dec_feeder with a behavioural
// stand-in for the decrypt core (block decrypt by table/mix, XOR with vector).
module tb_cbc_dec_feeder;

  localparam int PIPE_LAT   = 12;
  localparam int VEC_LAT    = 11;
  localparam int FIFO_DEPTH = 16;

  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  // Raw AES-128 block decryptions of CT1/CT2 under key 2b7e1516..., i.e. PT ^ previous block.
  localparam logic [127:0] D1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] D2  = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] MIX = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk = 1'b0;
  logic         reset;
  logic         iv_load;
  logic [127:0] iv_in;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic         ct_last;
  logic [127:0] cipher_text;
  logic [127:0] vector;
  logic [127:0] decrypted_plain_text;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         pt_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] ct_arr [64];
  logic [127:0] ex_arr [64];

  always #5 clk = ~clk;

  cbc_dec_feeder #(
    .DATA_W(128), .PIPE_LAT(PIPE_LAT), .VEC_LAT(VEC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .iv_load(iv_load), .iv_in(iv_in),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
    .cipher_text(cipher_text), .vector(vector),
    .decrypted_plain_text(decrypted_plain_text),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .busy(busy)
  );

  // Block decrypt of the stand-in core: real AES results for the NIST blocks.
  function automatic logic [127:0] blk_dec(input logic [127:0] c);
    if (c == CT1) return D1;
    if (c == CT2) return D2;
    return {c[63:0], c[127:64]} ^ MIX;
  endfunction

  function automatic logic [127:0] gen(input int set, input int i);
    return {32'(set), 32'(i), 32'hA5C30000 ^ 32'(i * 7), 32'(i) ^ 32'h12345678};
  endfunction

  // Core stand-in: vector sampled 11 edges after cipher_text updates, result valid 12 after.
  logic [127:0] d_pipe [10];
  logic [127:0] core_out;
  always @(posedge clk) begin
    d_pipe[0] <= blk_dec(cipher_text);
    for (int i = 1; i < 10; i++) d_pipe[i] <= d_pipe[i-1];
    core_out <= d_pipe[9] ^ vector;
  end
  assign decrypted_plain_text = core_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_iv(input logic [127:0] iv);
    iv_in   = iv;
    iv_load = 1'b1;
    step();
    iv_load = 1'b0;
    iv_in   = '0;
  endtask

  task automatic wait_pt(input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (!pt_valid && n < max_cyc) begin
      step();
      n++;
    end
    ok = pt_valid;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({ct_ready, pt_valid, pt_last, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {ct_ready, pt_valid, pt_last, busy});
    end
    checks++;
    if (cipher_text !== '0 || vector !== '0) begin
      errors++;
      $display("FAIL reset_core_if got ct=%h vec=%h want 0", cipher_text, vector);
    end
    checks++;
    if (pt_data !== '0) begin
      errors++;
      $display("FAIL reset_pt_data got %h want 0", pt_data);
    end
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || ct_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b ct_ready=%b want 0 0", busy, ct_ready);
    end
  endtask

  task automatic test_nist();
    bit ok;
    pt_ready = 1'b0;
    do_iv(IV1);
    checks++;
    if (busy !== 1'b1 || ct_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_after_iv got busy=%b ct_ready=%b want 1 1", busy, ct_ready);
    end
    ct_valid = 1'b1; ct_data = CT1; ct_last = 1'b0;
    step();
    ct_data = CT2; ct_last = 1'b1;
    step();
    ct_valid = 1'b0; ct_last = 1'b0; ct_data = '0;
    checks++;
    if (ct_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_state got ct_ready=%b busy=%b want 0 1", ct_ready, busy);
    end
    wait_pt(30, ok);
    checks++;
    if (!ok || pt_data !== PT1 || pt_last !== 1'b0) begin
      errors++;
      $display("FAIL nist_pt1 got v=%b %h last=%b want 1 %h 0", pt_valid, pt_data, pt_last, PT1);
    end
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    wait_pt(5, ok);
    checks++;
    if (!ok || pt_data !== PT2 || pt_last !== 1'b1) begin
      errors++;
      $display("FAIL nist_pt2 got v=%b %h last=%b want 1 %h 1", pt_valid, pt_data, pt_last, PT2);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nist_busy_before_pop got %b want 1", busy);
    end
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    wait_idle(5, ok);
    checks++;
    if (!ok || pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL nist_busy_fall got busy=%b pt_valid=%b want 0 0", busy, pt_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int nrdy;
    int lat;
    logic [127:0] iv;
    iv = 128'h0badc0de_11223344_55667788_99aabbcc;
    pt_ready = 1'b1;
    do_iv(iv);
    for (int i = 0; i < 4; i++) begin
      ct_arr[i] = gen(2, i);
      ex_arr[i] = blk_dec(ct_arr[i]) ^ ((i == 0) ? iv : ct_arr[(i == 0) ? 0 : i-1]);
    end
    nrdy = 0;
    for (int i = 0; i < 4; i++) begin
      ct_valid = 1'b1; ct_data = ct_arr[i]; ct_last = (i == 3);
      if (ct_ready) nrdy++;
      step();
    end
    ct_valid = 1'b0; ct_last = 1'b0;
    checks++;
    if (nrdy != 4) begin
      errors++;
      $display("FAIL b2b_accepts got %0d want 4", nrdy);
    end
    lat = 4;
    while (!pt_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat != PIPE_LAT + 1) begin
      errors++;
      $display("FAIL b2b_latency got %0d want %0d", lat, PIPE_LAT + 1);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pt_valid !== 1'b1 || pt_data !== ex_arr[k] || pt_last !== (k == 3)) begin
        errors++;
        $display("FAIL b2b_out%0d got v=%b %h last=%b want 1 %h %b",
                 k, pt_valid, pt_data, pt_last, ex_arr[k], (k == 3));
      end
      step();
    end
    checks++;
    if (pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got %b want 0", pt_valid);
    end
    wait_idle(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit acc;
    bit seen_ready;
    int in_i;
    int out_i;
    int cyc;
    logic [127:0] iv;
    iv = 128'hfeedface_cafebeef_01234567_89abcdef;
    for (int i = 0; i < 40; i++) begin
      ct_arr[i] = gen(3, i);
      ex_arr[i] = blk_dec(ct_arr[i]) ^ ((i == 0) ? iv : ct_arr[(i == 0) ? 0 : i-1]);
    end
    pt_ready = 1'b0;
    do_iv(iv);
    in_i = 0; out_i = 0;
    ct_valid = 1'b1; ct_data = ct_arr[0]; ct_last = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      acc = ct_valid && ct_ready;
      step();
      if (acc) begin
        in_i++;
        ct_data = ct_arr[in_i];
        ct_last = (in_i == 39);
      end
    end
    checks++;
    if (in_i != FIFO_DEPTH || ct_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_credit_stop got accepts=%0d ct_ready=%b want %0d 0", in_i, ct_ready, FIFO_DEPTH);
    end
    pt_ready = 1'b1;
    seen_ready = 1'b0;
    cyc = 0;
    while (out_i < 40 && cyc < 400) begin
      acc = ct_valid && ct_ready;
      if (ct_ready) seen_ready = 1'b1;
      if (pt_valid) begin
        checks++;
        if (pt_data !== ex_arr[out_i] || pt_last !== (out_i == 39)) begin
          errors++;
          $display("FAIL bp_out%0d got %h last=%b want %h %b",
                   out_i, pt_data, pt_last, ex_arr[out_i], (out_i == 39));
        end
        out_i++;
      end
      step();
      cyc++;
      if (acc) begin
        in_i++;
        if (in_i == 40) begin
          ct_valid = 1'b0; ct_last = 1'b0;
        end else begin
          ct_data = ct_arr[in_i];
          ct_last = (in_i == 39);
        end
      end
    end
    checks++;
    if (!seen_ready) begin
      errors++;
      $display("FAIL bp_ready_restore got 0 want 1");
    end
    checks++;
    if (out_i != 40 || in_i != 40) begin
      errors++;
      $display("FAIL bp_count got in=%0d out=%0d want 40 40", in_i, out_i);
    end
    pt_ready = 1'b0;
    wait_idle(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    bit acc;
    bit pop;
    bit emerge;
    bit m_ready;
    bit full_pp;
    logic [11:0] hist;
    int m_inf;
    int m_fifo;
    int in_i;
    int out_i;
    int cyc;
    logic [127:0] iv;
    iv = 128'h13579bdf_2468ace0_0f0f0f0f_f0f0f0f0;
    for (int i = 0; i < 40; i++) begin
      ct_arr[i] = gen(4, i);
      ex_arr[i] = blk_dec(ct_arr[i]) ^ ((i == 0) ? iv : ct_arr[(i == 0) ? 0 : i-1]);
    end
    pt_ready = 1'b0;
    do_iv(iv);
    hist = '0; m_inf = 0; m_fifo = 0; in_i = 0; out_i = 0; cyc = 0;
    ct_valid = 1'b1; ct_data = ct_arr[0]; ct_last = 1'b0;
    while (out_i < 40 && cyc < 400) begin
      emerge  = hist[11];
      m_ready = (m_inf + m_fifo < FIFO_DEPTH);
      acc     = ct_valid && m_ready;
      if (m_fifo == FIFO_DEPTH - 1 && emerge) pt_ready = 1'b1;
      pop     = pt_ready && (m_fifo > 0);
      full_pp = pop && emerge && (m_fifo == FIFO_DEPTH - 1);
      checks++;
      if (int'(dut.inflight) != m_inf || int'(dut.fifo_count) != m_fifo ||
          (ct_valid && ct_ready !== m_ready)) begin
        errors++;
        $display("FAIL sim_counters cyc%0d got inf=%0d fifo=%0d rdy=%b want %0d %0d %b",
                 cyc, dut.inflight, dut.fifo_count, ct_ready, m_inf, m_fifo, m_ready);
      end
      if (pop) begin
        checks++;
        if (pt_data !== ex_arr[out_i]) begin
          errors++;
          $display("FAIL sim_out%0d got %h want %h", out_i, pt_data, ex_arr[out_i]);
        end
        out_i++;
      end
      step();
      cyc++;
      m_inf  = m_inf + int'(acc) - int'(emerge);
      m_fifo = m_fifo + int'(emerge) - int'(pop);
      hist   = {hist[10:0], acc};
      if (full_pp) begin
        checks++;
        if (int'(dut.fifo_count) != FIFO_DEPTH - 1) begin
          errors++;
          $display("FAIL sim_full_push_pop got %0d want %0d", dut.fifo_count, FIFO_DEPTH - 1);
        end
      end
      if (acc) begin
        in_i++;
        if (in_i == 40) begin
          ct_valid = 1'b0; ct_last = 1'b0;
        end else begin
          ct_data = ct_arr[in_i];
          ct_last = (in_i == 39);
        end
      end
    end
    checks++;
    if (out_i != 40) begin
      errors++;
      $display("FAIL sim_count got %0d want 40", out_i);
    end
    pt_ready = 1'b0;
    wait_idle(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sim_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stale;
    logic [127:0] iv;
    logic [127:0] blk;
    iv = 128'h55555555_aaaaaaaa_33333333_cccccccc;
    pt_ready = 1'b0;
    do_iv(iv);
    for (int i = 0; i < 5; i++) begin
      ct_valid = 1'b1; ct_data = gen(5, i); ct_last = 1'b0;
      step();
    end
    ct_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({ct_ready, pt_valid, pt_last, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ctrl got %b want 0000", {ct_ready, pt_valid, pt_last, busy});
    end
    checks++;
    if (cipher_text !== '0 || vector !== '0 || pt_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_data got ct=%h vec=%h pt=%h want 0", cipher_text, vector, pt_data);
    end
    step();
    reset = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pt_valid) stale = 1'b1;
      step();
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rst_mid_stale got pt_valid=1 want 0");
    end
    iv  = 128'h0123456789abcdef0123456789abcdef;
    blk = gen(6, 0);
    do_iv(iv);
    ct_valid = 1'b1; ct_data = blk; ct_last = 1'b1;
    step();
    ct_valid = 1'b0; ct_last = 1'b0;
    wait_pt(30, ok);
    checks++;
    if (!ok || pt_data !== (blk_dec(blk) ^ iv) || pt_last !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_new got v=%b %h last=%b want 1 %h 1", pt_valid, pt_data, pt_last, blk_dec(blk) ^ iv);
    end
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    wait_idle(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_iv_ignore();
    bit ok;
    logic [127:0] iv;
    logic [127:0] a;
    logic [127:0] b;
    iv = 128'h1111111122222222333333334444444f;
    a  = gen(7, 0);
    b  = gen(7, 1);
    pt_ready = 1'b0;
    do_iv(iv);
    ct_valid = 1'b1; ct_data = a; ct_last = 1'b0;
    step();
    ct_valid = 1'b0;
    do_iv(128'hdeaddeaddeaddeaddeaddeaddeaddead);
    checks++;
    if (busy !== 1'b1 || ct_ready !== 1'b1) begin
      errors++;
      $display("FAIL ivign_state got busy=%b ct_ready=%b want 1 1", busy, ct_ready);
    end
    ct_valid = 1'b1; ct_data = b; ct_last = 1'b1;
    step();
    ct_valid = 1'b0; ct_last = 1'b0;
    wait_pt(30, ok);
    checks++;
    if (!ok || pt_data !== (blk_dec(a) ^ iv)) begin
      errors++;
      $display("FAIL ivign_pt0 got v=%b %h want 1 %h", pt_valid, pt_data, blk_dec(a) ^ iv);
    end
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    wait_pt(5, ok);
    checks++;
    if (!ok || pt_data !== (blk_dec(b) ^ a) || pt_last !== 1'b1) begin
      errors++;
      $display("FAIL ivign_pt1 got v=%b %h last=%b want 1 %h 1", pt_valid, pt_data, pt_last, blk_dec(b) ^ a);
    end
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    wait_idle(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ivign_idle got busy=%b want 0", busy);
    end
  endtask

  initial begin
    reset = 1'b1; iv_load = 1'b0; iv_in = '0;
    ct_valid = 1'b0; ct_data = '0; ct_last = 1'b0; pt_ready = 1'b0;
    #2;
    test_reset();
    test_nist();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_iv_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
